// File: rtl/banked_bram_pkg.sv
// Shared definitions for banked_bram: default geometry, clear-FSM states
// and the address-width helper.
package banked_bram_pkg;

  localparam int DEF_LANE_WIDTH = 8;
  localparam int DEF_NUM_LANES  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Ceiling log2, minimum 1 for any depth >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/bram_lane.sv
// One lane of banked_bram: LANE_WIDTH x RAM_DEPTH array, single write port,
// registered read port. Read-first on same-address collisions. The array
// itself is never reset; only the read register is.
module bram_lane #(
  parameter int LANE_WIDTH = 8,
  parameter int RAM_DEPTH  = 256,
  parameter int AW         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [LANE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [LANE_WIDTH-1:0] rdata
);

  logic [LANE_WIDTH-1:0] mem [RAM_DEPTH];

  // array write, no reset on contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read; holds when no read is accepted
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/banked_bram.sv
// banked_bram: NUM_LANES byte-lane RAM with per-lane write enables, 1- or
// 2-cycle read pipeline and a hardware clear engine that zeroes the array
// after reset or on clr.
// Optional feature: define BANKED_BRAM_BYPASS_EN for write-first behaviour on
// same-cycle same-address write/read (default build is read-first).
module banked_bram
  import banked_bram_pkg::*;
#(
  parameter int  LANE_WIDTH   = DEF_LANE_WIDTH,
  parameter int  NUM_LANES    = DEF_NUM_LANES,
  parameter int  RAM_DEPTH    = 256,
  parameter int  READ_LATENCY = 1,
  localparam int AW           = clog2(RAM_DEPTH),
  localparam int W            = LANE_WIDTH * NUM_LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wea,
  input  logic [NUM_LANES-1:0] wea_lane,
  input  logic [AW-1:0]        addra,
  input  logic [W-1:0]         dina,
  input  logic                 enb,
  input  logic [AW-1:0]        addrb,
  input  logic                 clr,
  output logic [W-1:0]         doutb,
  output logic                 doutb_valid,
  output logic                 busy
);

  localparam logic [AW-1:0] LAST = AW'(RAM_DEPTH - 1);

  clr_state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          wr_acc, rd_acc;

  logic [NUM_LANES-1:0]                 lane_we;
  logic [AW-1:0]                        lane_waddr;
  logic [NUM_LANES-1:0][LANE_WIDTH-1:0] lane_wdata, lane_rdata, rd_word;
  logic [READ_LATENCY-1:0]              vld_pipe;

  assign busy   = (state == CLEAR);
  assign wr_acc = wea & ~busy & ~rst;
  assign rd_acc = enb & ~busy & ~rst;

  // clear FSM state and counter; reset starts a clear from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // clear FSM next state: sweep cnt 0..RAM_DEPTH-1, stop exactly at the last entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (clr) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
      CLEAR: if (cnt == LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // write port mux: clear engine owns every lane while busy
  always_comb begin
    lane_waddr = addra;
    lane_wdata = dina;
    lane_we    = wea_lane & {NUM_LANES{wr_acc}};
    if (busy) begin
      lane_waddr = cnt;
      lane_wdata = '0;
      lane_we    = '1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bram_lane #(
      .LANE_WIDTH(LANE_WIDTH),
      .RAM_DEPTH (RAM_DEPTH),
      .AW        (AW)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .we   (lane_we[i]),
      .waddr(lane_waddr),
      .wdata(lane_wdata[i]),
      .re   (rd_acc),
      .raddr(addrb),
      .rdata(lane_rdata[i])
    );
  end

`ifdef BANKED_BRAM_BYPASS_EN
  logic                                 byp_hit;
  logic [NUM_LANES-1:0]                 byp_mask;
  logic [NUM_LANES-1:0][LANE_WIDTH-1:0] byp_data;

  // remember whether the accepted read collided with a same-cycle write
  always_ff @(posedge clk) begin
    if (rst)         byp_hit <= 1'b0;
    else if (rd_acc) byp_hit <= wr_acc && (addra == addrb);
  end

  // colliding write payload, only meaningful when byp_hit is set
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      byp_mask <= wea_lane;
      byp_data <= dina;
    end
  end

  // merge written lanes over the read-first array data
  always_comb begin
    rd_word = lane_rdata;
    for (int i = 0; i < NUM_LANES; i++)
      if (byp_hit && byp_mask[i]) rd_word[i] = byp_data[i];
  end
`else
  assign rd_word = lane_rdata;
`endif

  // read valid shift register; stage 0 is the lane read register
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= READ_LATENCY'({vld_pipe, rd_acc});
  end

  assign doutb_valid = vld_pipe[READ_LATENCY-1];

  if (READ_LATENCY == 1) begin : g_lat1
    assign doutb = rd_word;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [W-1:0] dout_q;
    // output stage: capture the word only when a read completes, else hold
    always_ff @(posedge clk) begin
      if (rst)              dout_q <= '0;
      else if (vld_pipe[0]) dout_q <= rd_word;
    end
    assign doutb = dout_q;
  end else begin : g_bad_latency
    $error("banked_bram: READ_LATENCY must be 1 or 2");
  end

endmodule
